// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   InstW       : instruction / address width
//   DefDepth    : default prefetch queue depth
//   DefResetPc  : default first fetch address
//   fetch_state_e : prefetch FSM states (run / flush)
//   fetch_entry_t : one queue entry, {pc, inst}
package mips_pkg;

    localparam int unsigned InstW      = 32;
    localparam int unsigned DefDepth   = 4;
    localparam logic [31:0] DefResetPc = 32'h0000_0000;

    typedef enum logic {
        StRun,
        StFlush
    } fetch_state_e;

    typedef struct packed {
        logic [InstW-1:0] pc;
        logic [InstW-1:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low bits are ignored.
    function automatic logic [InstW-1:0] word_align(input logic [InstW-1:0] addr);
        return {addr[InstW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
// Ports:
//   clock_i  : rising-edge clock
//   reset_i  : asynchronous active-high reset (storage cleared so the head reads 0)
//   push_i   : write data_i this cycle
//   data_i   : entry to write
//   pop_i    : drop the head entry this cycle (ignored when empty)
//   flush_i  : empty the queue at the clock edge; overrides push/pop
//   data_o   : head entry (registered storage)
//   valid_o  : queue holds at least one entry
//   count_o  : number of entries held
module fetch_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [Width-1:0]       data_o,
    output logic                   valid_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCount = Depth[PtrW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    // A pop frees the slot being written, so push-while-full is fine alongside a pop.
    assign do_push = push_i & ((count_q != FullCount) | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PtrW + 1)'(1);
                2'b01:   count_d = count_q - (PtrW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: keeps a small queue of fetched instructions ahead of decode.
// Requests are issued on a credit basis (queued + outstanding < DEPTH) so a response
// always has a queue slot. A redirect empties the queue, restarts fetch at the new
// address and, while older requests are still in flight, discards their responses
// in the FLUSH state.
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   redirect, redirect_pc   : restart fetch at redirect_pc (low two bits ignored)
//   imem_req/addr/gnt       : memory request channel; addr held while req & !gnt
//   imem_rvalid/rdata       : in-order memory responses
//   inst_valid/inst/inst_pc : queue head presented to decode
//   inst_ready              : decode consumes the head this cycle
// Optional (macro PREFETCH_PERF_EN):
//   perf_drop  : saturating count of discarded responses
//   perf_empty : saturating count of out-of-reset cycles with inst_valid low
module inst_prefetch
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = DefDepth,
    parameter logic [31:0] RESET_PC = DefResetPc
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0] perf_drop,
    output logic [15:0] perf_empty
`endif
);

    localparam int unsigned    CntW     = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [InstW-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]  outstanding_q, outstanding_d;
    logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CntW-1:0]  q_count;
    logic [CntW:0]    in_flight;
    logic             grant;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign in_flight = {1'b0, q_count} + {1'b0, outstanding_q};

    // Request is combinational so it can drop in the redirect cycle itself.
    assign imem_req  = ~reset & (state_q == StRun) & ~redirect & (in_flight < DepthLim);
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req & imem_gnt;

    // Responses in RUN belong to the current stream. The oldest outstanding request
    // was issued at fetch_pc - 4*outstanding, which gives the PC of this response.
    assign push          = imem_rvalid & (state_q == StRun) & ~redirect;
    assign push_entry.pc = fetch_pc_q - InstW'({outstanding_q, 2'b00});
    assign push_entry.inst = imem_rdata;
    assign pop           = inst_valid & inst_ready;

    fetch_fifo #(
        .Depth (DEPTH),
        .Width ($bits(fetch_entry_t))
    ) u_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_o  (head),
        .valid_o (inst_valid),
        .count_o (q_count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CntW'(grant) - CntW'(imem_rvalid);
        if (redirect) begin
            // Whatever is still in flight after this cycle's response must be dropped.
            fetch_pc_d = word_align(redirect_pc);
            drop_cnt_d = outstanding_q - CntW'(imem_rvalid);
            state_d    = (drop_cnt_d != '0) ? StFlush : StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (grant) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                StFlush: begin
                    if (imem_rvalid) begin
                        drop_cnt_d = drop_cnt_q - CntW'(1);
                        if (drop_cnt_q == CntW'(1)) begin
                            state_d = StRun;
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifdef PREFETCH_PERF_EN
    logic        drop_evt;
    logic [15:0] perf_drop_q;
    logic [15:0] perf_empty_q;

    // A response coinciding with a redirect is discarded as well.
    assign drop_evt = imem_rvalid & (redirect | (state_q == StFlush));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_drop_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (drop_evt && (perf_drop_q != 16'hFFFF)) begin
                perf_drop_q <= perf_drop_q + 16'd1;
            end
            if (!inst_valid && (perf_empty_q != 16'hFFFF)) begin
                perf_empty_q <= perf_empty_q + 16'd1;
            end
        end
    end

    assign perf_drop  = perf_drop_q;
    assign perf_empty = perf_empty_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
`timescale 1ns/1ps
module tb_inst_prefetch;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef PREFETCH_PERF_EN
    logic [15:0] perf_drop;
    logic [15:0] perf_empty;
`endif

    always #5 clock = ~clock;

    inst_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_drop   (perf_drop),
        .perf_empty  (perf_empty)
`endif
    );

    // Memory request in flight: DUT address (for data), model PC and stream epoch.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] mpc;
        int          epoch;
        int          due;
    } pend_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    pend_t       pend[$];
    ent_t        mq[$];
    logic [31:0] post_pcs[$];
    int          total = 0;
    int          bad = 0;
    int          epoch = 0;
    int          cyc = 0;
    int          grants = 0;
    int          drops = 0;
    int          first_req_cyc = -1;
    int          first_valid_cyc = -1;
    int          redirect_cyc = -1;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] m_fetch_pc = '0;
    logic        obs_v [16];
    logic [31:0] obs_pc [16];
    logic        drv_redirect = 1'b0;
    logic [31:0] drv_rpc = '0;
    logic        drv_gnt = 1'b0;
    logic        drv_ready = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] post_pc(input int k);
        if (post_pcs.size() > k) return post_pcs[k];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        redirect = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        inst_ready = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        @(posedge clock);
        #1;
        check("rst_req_hold", 32'(imem_req), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
`ifdef PREFETCH_PERF_EN
        check("rst_perf_drop", 32'(perf_drop), 32'd0);
        check("rst_perf_empty", 32'(perf_empty), 32'd0);
`endif
        pend.delete();
        mq.delete();
        post_pcs.delete();
        epoch++;
        m_fetch_pc = 32'h0000_0000;
        cyc = 0;
        grants = 0;
        drops = 0;
        first_req_cyc = -1;
        first_valid_cyc = -1;
        redirect_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            obs_v[i] = 1'b0;
            obs_pc[i] = '0;
        end
        drv_redirect = 1'b0;
        drv_rpc = '0;
        drv_gnt = 1'b1;
        drv_ready = 1'b1;
        lat_min = 1;
        lat_max = 1;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step();
        bit    stale;
        bit    exp_req;
        bit    exp_valid;
        int    lat;
        pend_t p;
        ent_t  e;
        @(negedge clock);
        cyc++;
        reset = 1'b0;
        redirect = drv_redirect;
        redirect_pc = drv_rpc;
        imem_gnt = drv_gnt;
        inst_ready = drv_ready;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata = memf(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        stale = 1'b0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale = 1'b1;
        exp_req = !drv_redirect && !stale && (mq.size() + pend.size() < DEPTH);
        exp_valid = (mq.size() != 0);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_fetch_pc);
        check("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid && inst_valid) begin
            check("inst_pc", inst_pc, mq[0].pc);
            check("inst", inst, mq[0].data);
        end
        if (cyc < 16) begin
            obs_v[cyc] = inst_valid;
            obs_pc[cyc] = inst_pc;
        end
        if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (inst_valid && inst_ready && !drv_redirect) post_pcs.push_back(inst_pc);

        if (exp_valid && drv_ready) void'(mq.pop_front());
        if (imem_rvalid) begin
            p = pend.pop_front();
            if (p.epoch == epoch && !drv_redirect) begin
                e.pc = p.mpc;
                e.data = memf(p.mpc);
                mq.push_back(e);
            end else begin
                drops++;
            end
        end
        if (imem_req && imem_gnt) begin
            grants++;
            lat = (lat_min == lat_max) ? lat_min : int'($urandom_range(lat_max, lat_min));
            p.addr = imem_addr;
            p.mpc = m_fetch_pc;
            p.epoch = epoch;
            p.due = cyc + lat;
            pend.push_back(p);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (drv_redirect) begin
            epoch++;
            mq.delete();
            post_pcs.delete();
            m_fetch_pc = {drv_rpc[31:2], 2'b00};
            redirect_cyc = cyc;
            first_req_cyc = -1;
            first_valid_cyc = -1;
        end
    endtask

    initial begin
        // Streaming after reset with single-cycle memory.
        do_reset();
        repeat (12) step();
        check("a_first_req", 32'(first_req_cyc), 32'd1);
        check("a_valid_c2", 32'(obs_v[2]), 32'd0);
        check("a_valid_c3", 32'(obs_v[3]), 32'd1);
        check("a_pc_c3", obs_pc[3], 32'h0);
        check("a_pc_c4", obs_pc[4], 32'h4);
        check("a_pc_c5", obs_pc[5], 32'h8);
        check("a_pc_c6", obs_pc[6], 32'hC);

        // Decode stalled: credit stops at DEPTH.
        do_reset();
        drv_ready = 1'b0;
        repeat (10) step();
        check("b_grants", 32'(grants), 32'd4);
        check("b_req_low", 32'(imem_req), 32'd0);
        check("b_outstanding", 32'(pend.size()), 32'd0);
        check("b_inst_pc", inst_pc, 32'h0);

        // Redirect with two requests in flight, 3-cycle memory.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        repeat (2) step();
        drv_gnt = 1'b0;
        drv_redirect = 1'b1;
        drv_rpc = 32'h0000_0103;
        step();
        drv_redirect = 1'b0;
        drv_gnt = 1'b1;
        repeat (10) step();
        check("c_drops", 32'(drops), 32'd2);
        check("c_first_req", 32'(first_req_cyc), 32'd6);
        check("c_pc0", post_pc(0), 32'h100);
        check("c_pc1", post_pc(1), 32'h104);
`ifdef PREFETCH_PERF_EN
        check("c_perf_drop", 32'(perf_drop), 32'd2);
`endif

        // Redirect coincident with a response, one more outstanding.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        repeat (2) step();
        drv_gnt = 1'b0;
        step();
        drv_redirect = 1'b1;
        drv_rpc = 32'h0000_0200;
        step();
        drv_redirect = 1'b0;
        drv_gnt = 1'b1;
        repeat (10) step();
        check("d_drops", 32'(drops), 32'd2);
        check("d_first_req", 32'(first_req_cyc), 32'd6);
        check("d_pc0", post_pc(0), 32'h200);

        // Wrap-around redirect from idle, minimum latency.
        do_reset();
        drv_gnt = 1'b0;
        repeat (3) step();
        drv_redirect = 1'b1;
        drv_rpc = 32'hFFFF_FFFC;
        step();
        drv_redirect = 1'b0;
        drv_gnt = 1'b1;
        repeat (8) step();
        check("e_req_lat", 32'(first_req_cyc - redirect_cyc), 32'd1);
        check("e_valid_lat", 32'(first_valid_cyc - redirect_cyc), 32'd3);
        check("e_pc0", post_pc(0), 32'hFFFF_FFFC);
        check("e_pc1", post_pc(1), 32'h0000_0000);

        // Randomized traffic with a mid-transaction reset.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            lat_min = 1;
            lat_max = 4;
            drv_gnt = ($urandom_range(9, 0) < 7);
            drv_ready = ($urandom_range(9, 0) < 6);
            drv_redirect = ($urandom_range(99, 0) < 4);
            drv_rpc = $urandom;
            if ($urandom_range(3, 0) == 0) drv_rpc = 32'hFFFF_FFF0 | (drv_rpc & 32'hF);
            step();
        end

`ifdef PREFETCH_PERF_EN
        // Long starvation saturates the empty-cycle counter.
        do_reset();
        drv_gnt = 1'b0;
        repeat (70000) step();
        check("f_perf_empty", 32'(perf_empty), 32'h0000_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameters: DEPTH, 4, queue entries (power of 2, 2..16); RESET_PC, 32'h0000_0000, first fetch address.
REQ-002 SHALL have ports, in this order:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- redirect  in  1  flush and restart fetch at redirect_pc (taken branch, jump, jr from decode).
- redirect_pc  in  32  new fetch address; bits[1:0] ignored, treated as 0.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned read address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; responses return in request order.
- imem_rdata  in  32  read data.
- inst_valid  out  1  inst/inst_pc hold a valid instruction for decode.
- inst  out  32  instruction word.
- inst_pc  out  32  address of inst.
- inst_ready  in  1  decode accepts inst this cycle.

Function
REQ-003 SHALL use an FSM with states RUN and FLUSH.
REQ-004 In RUN, SHALL assert imem_req when (queued + outstanding) < DEPTH and redirect is low.
REQ-005 SHALL hold imem_addr stable while imem_req is high and imem_gnt is low.
REQ-006 On imem_req & imem_gnt, SHALL increment fetch_pc by 4 (mod 2^32, wrap without error) and increment outstanding.
REQ-007 In RUN, SHALL write imem_rdata and its PC into the queue on imem_rvalid and decrement outstanding.
REQ-008 A response arriving with the queue full SHALL be impossible by construction (REQ-004 credit rule).
REQ-009 SHALL drive inst_valid from a registered queue head; earliest inst_valid is the cycle after the imem_rvalid that filled an empty queue.
REQ-010 Each cycle with inst_valid & inst_ready SHALL pop exactly one entry; push and pop in the same cycle SHALL leave the count unchanged.
REQ-011 On redirect, the queue SHALL be emptied and fetch_pc loaded with {redirect_pc[31:2],2'b00} at the clock edge.
- inst_valid SHALL be 0 the following cycle.
- A pop in the redirect cycle is treated as consumed.
- imem_req SHALL be 0 in the redirect cycle.
REQ-012 On redirect, drop_cnt SHALL be loaded with outstanding minus (imem_rvalid ? 1 : 0).
- If the result is nonzero, next state SHALL be FLUSH, otherwise RUN.
REQ-013 In FLUSH:
- imem_req SHALL be 0.
- each imem_rvalid SHALL decrement drop_cnt and its data SHALL be discarded.
- drop_cnt reaching 0 SHALL transition to RUN.
REQ-014 A redirect during FLUSH SHALL reload fetch_pc and recompute drop_cnt per REQ-012; the state remains FLUSH if drop_cnt stays nonzero.
REQ-015 Minimum redirect-to-inst_valid latency with no outstanding requests and single-cycle memory SHALL be 3 cycles (req at N+1, rvalid N+2, inst_valid N+3).

Reset
REQ-016 While reset is high, the block SHALL set:
- state = RUN.
- fetch_pc = RESET_PC.
- queue empty; outstanding = drop_cnt = 0.
- imem_req = 0, inst_valid = 0, inst = 0, inst_pc = 0.
REQ-017 First imem_req SHALL assert in the first cycle after reset deasserts.
REQ-018 Reset mid-transaction SHALL abandon all outstanding responses; the memory is reset alongside.

Configuration
REQ-019 With macro PREFETCH_PERF_EN defined, SHALL add output ports:
- perf_drop  out  16  saturating count of discarded responses.
- perf_empty  out  16  saturating count of cycles with inst_valid=0 outside reset.
Both SHALL reset to 0.
REQ-020 Without PREFETCH_PERF_EN, these ports and their counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-021 Shared package mips_pkg SHALL hold the FSM state typedef (RUN, FLUSH), default DEPTH, RESET_PC, and the instruction word width (32).
REQ-022 Queue storage SHALL be a sub-module fetch_fifo (synchronous FIFO, data = {pc, inst}, push/pop/flush, count output); credit, FSM and PC logic stay in inst_prefetch.

Verification
REQ-023 Reset release, mem always gnt with 1-cycle rvalid, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8, ... one per cycle from cycle 3; inst = memory contents.
REQ-024 inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants, then imem_req=0 with outstanding 0; inst_pc holds 0x0 stable.
REQ-025 mem latency 3 cycles, 2 requests outstanding, redirect to 0x100 -> state FLUSH, 2 responses dropped, no req until drop_cnt=0; next inst_pc=0x100.
REQ-026 redirect coincident with imem_rvalid and one other outstanding -> drop_cnt=1; the coincident data never appears on inst.
REQ-027 redirect_pc=0xFFFF_FFFC -> inst_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-028 With PREFETCH_PERF_EN, run the REQ-025 scenario -> perf_drop=2; force 70000 empty cycles -> perf_empty=0xFFFF.
